frame_checker: RTL
==================

Name: frame_checker

Overview:
- Receive-side counterpart of the packet-filter frame source: an AXI-Stream sink that consumes 16-bit Ethernet-style frames, parses and validates them, and discards them.
- Frame layout: dst MAC, src MAC, length, type, payload.
- Validates destination MAC, declared length and minimum size, and accumulates a 32-bit payload byte-sum checksum.
- Exposes configuration, per-frame snapshot registers and saturating error/good counters on an 8-bit Avalon-MM slave. Used at the egress of the filter datapath and in loopback benches.

Parameters:
- CNT_W, 16, width of each frame counter (saturating).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- writedata  in  8  Avalon-MM write data
- write  in  1  Avalon-MM write strobe
- chipselect  in  1  Avalon-MM select
- address  in  8  Avalon-MM byte address
- read  in  1  Avalon-MM read strobe
- readdata  out  8  Avalon-MM read data, registered
- ingress_port_tdata  in  16  stream data
- ingress_port_tlast  in  1  last beat of frame
- ingress_port_tvalid  in  1  beat valid
- ingress_port_tready  out  1  sink ready

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state is sampled on posedge clk.
- Register map: 0-5 expected dst MAC bytes 0-5 (RW).
- Register 6 is CTRL (RW):
  - bit0 ENABLE
  - bit1 PROMISC
  - bit2 CLR, write-1, self-clears the next cycle, reads 0.
- Read-only registers:
  - 8-9 good count LSB/MSB
  - 10-11 dst-mismatch count
  - 12-13 length-error count
  - 14-15 runt count
  - 16-19 last checksum bytes 0-3
  - 20-21 last length field byte0/byte1
  - 22-23 last type byte0/byte1
  - 24-29 last src MAC bytes 0-5
  - 30 STATUS: bit0 in_frame, bit1 last_good.
- Unmapped reads return 0x00; writes to RO or unmapped addresses are ignored.
- Reads: readdata is valid the cycle after chipselect&&read. It is 0x00 in every other cycle.
- Reset values: all registers 0, readdata 0, tready 0, state IDLE.
- tready is a registered copy of CTRL.ENABLE (1 cycle after the write). A beat is accepted only when tvalid&&tready.
- Beat mapping, with tdata[15:8] carrying the lower-numbered byte:
  - beats 0-2 dst MAC {b0,b1},{b2,b3},{b4,b5}
  - beats 3-5 src MAC likewise
  - beat 6 length {len byte0 (LSB), len byte1 (MSB)}
  - beat 7 type {type byte0, type byte1}
  - beats 8.. payload.
- Expected payload beats P = ceil(len/2), 16-bit arithmetic.
- Checksum: 32-bit, wrap-around. Adds both payload bytes per beat. If len is odd, the final beat adds only tdata[15:8].
- A 16-bit beat counter counts accepted beats in the frame.
- FSM IDLE:
  - First accepted beat loads the dst word and goes to HDR, with beat count 1.
  - tlast on that beat counts as runt and stays IDLE.
- FSM HDR: captures beats 1-7.
  - tlast before beat 7 counts as runt and returns to IDLE.
  - At beat 7, go to PAY, or evaluate immediately if tlast.
- FSM PAY:
  - Accumulate the checksum.
  - tlast on payload beat P means frame complete.
  - tlast before P means length error. Non-tlast beat P means length error and go to DRAIN.
  - len=0: tlast must be on beat 7, otherwise length error and DRAIN.
- FSM DRAIN: discards beats until tlast, then IDLE. No further counter updates for that frame.
- Frame evaluation at completion, one counter per frame, priority length error > dst mismatch > good.
  - dst mismatch applies only when PROMISC=0 and the captured dst differs from regs 0-5.
  - Snapshot registers (checksum, len, type, src) update on every non-runt completed or length-error frame.
  - last_good is set on good and cleared otherwise.
- Counters saturate at all-ones and do not wrap.
- CLR zeroes all counters and snapshots. If CLR coincides with an increment, the counter is 0 after the cycle (clear wins).
- ENABLE cleared mid-frame: tready drops and the FSM holds its state. Parsing resumes on re-enable.
- Reset mid-frame: return to IDLE; the partial frame is not counted.
- in_frame = (state != IDLE).

Test Plan:
- Enable, expected dst 02:00:00:00:00:01.
  - Stimulus: a frame to that dst with src 0A..0F, len=4, type 0x0800, payload 11 22 33 44, tlast on beat 9.
  - Response: good=1, checksum=0x000000AA, len regs 04/00, last_good=1.
- Odd length: len=3, payload beats {0x10,0x20},{0x30,0xFF}.
  - Response: checksum=0x60 (0xFF ignored), good=1.
- Dst 02:00:00:00:00:02, PROMISC=0 then PROMISC=1.
  - Response: dst-mismatch=1 then good=1.
- Length errors: len=6 with tlast on beat 9 gives len-err=1. len=2 with 3 payload beats then tlast gives len-err=1, DRAIN, no other counters change.
- Runt: tlast on beat 4 gives runt=1 and snapshots unchanged. Follow with a toggled-tvalid good frame and ENABLE dropped for 5 cycles mid-frame: good=1 and the checksum is correct.
- Saturation/clear:
  - Force good count to 0xFFFF with 65535 frames (or via a shortened CNT_W=4 build): stays at max.
  - CLR in the same cycle as a good completion: count reads 0.
  - Reset asserted mid-payload: all regs 0, state IDLE.

Source files
------------

// File: rtl/frame_checker.sv
// AXI-Stream frame sink: parses 16-bit Ethernet-style frames (dst, src, length, type, payload),
// validates them, sums payload bytes and reports results through an 8-bit Avalon-MM register file.
module frame_checker #(
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  writedata,
   input  logic        write,
   input  logic        chipselect,
   input  logic [7:0]  address,
   input  logic        read,
   output logic [7:0]  readdata,
   input  logic [15:0] ingress_port_tdata,
   input  logic        ingress_port_tlast,
   input  logic        ingress_port_tvalid,
   output logic        ingress_port_tready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HDR   = 2'd1,
      ST_PAY   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [7:0]        exp_mac_r [6];
   logic              enable_r, promisc_r, clr_r, tready_r;
   logic [7:0]        readdata_r, rd_mux_s;
   logic [15:0]       beat_cnt_r, beat_cnt_s;
   logic [15:0]       dst_w_r [3];
   logic [15:0]       src_w_r [3];
   logic [15:0]       len_r, type_r;
   logic [31:0]       csum_r, csum_s;
   logic [CNT_W-1:0]  good_cnt_r, dmis_cnt_r, lerr_cnt_r, runt_cnt_r;
   logic [15:0]       good16_s, dmis16_s, lerr16_s, runt16_s;
   logic [31:0]       snap_csum_r;
   logic [15:0]       snap_len_r, snap_type_r;
   logic [15:0]       snap_src_r [3];
   logic              last_good_r;
   logic              accept_s, wr_s, clr_wr_s, clear_s;
   logic              runt_ev_s, lerr_ev_s, done_ev_s, dst_mis_s;
   logic [15:0]       pay_beats_s, pay_idx_s, frame_type_s;
   logic              last_pay_s;
   logic [31:0]       pay_add_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == {CNT_W{1'b1}}) begin
         return c;
      end else begin
         return c + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   function automatic logic [15:0] cnt16(input logic [CNT_W-1:0] c);
      return 16'(c);
   endfunction

   assign accept_s    = ingress_port_tvalid && tready_r;
   assign wr_s        = chipselect && write;
   assign clr_wr_s    = wr_s && (address == 8'd6) && writedata[2];
   // The CLR pulse clears on the write cycle and the cycle after, so a coinciding increment never survives.
   assign clear_s     = clr_wr_s || clr_r;
   assign pay_beats_s = {1'b0, len_r[15:1]} + {15'd0, len_r[0]};
   assign pay_idx_s   = beat_cnt_r - 16'd7;
   assign last_pay_s  = (pay_idx_s == pay_beats_s);
   assign pay_add_s   = (last_pay_s && len_r[0]) ? {24'd0, ingress_port_tdata[15:8]}
                      : {24'd0, ingress_port_tdata[15:8]} + {24'd0, ingress_port_tdata[7:0]};
   assign frame_type_s = ((state_r == ST_HDR) && (beat_cnt_r == 16'd7)) ? ingress_port_tdata : type_r;
   assign dst_mis_s   = !promisc_r &&
                        ({dst_w_r[0], dst_w_r[1], dst_w_r[2]} !=
                         {exp_mac_r[0], exp_mac_r[1], exp_mac_r[2],
                          exp_mac_r[3], exp_mac_r[4], exp_mac_r[5]});
   assign good16_s    = cnt16(good_cnt_r);
   assign dmis16_s    = cnt16(dmis_cnt_r);
   assign lerr16_s    = cnt16(lerr_cnt_r);
   assign runt16_s    = cnt16(runt_cnt_r);
   assign readdata    = readdata_r;
   assign ingress_port_tready = tready_r;

   // Frame parser next-state, beat count, checksum and per-frame verdict events.
   always_comb begin
      state_s    = state_r;
      beat_cnt_s = beat_cnt_r;
      csum_s     = csum_r;
      runt_ev_s  = 1'b0;
      lerr_ev_s  = 1'b0;
      done_ev_s  = 1'b0;
      if (accept_s) begin
         beat_cnt_s = beat_cnt_r + 16'd1;
         case (state_r)
            ST_IDLE: begin
               beat_cnt_s = 16'd1;
               csum_s     = 32'd0;
               if (ingress_port_tlast) begin
                  runt_ev_s = 1'b1;
                  state_s   = ST_IDLE;
               end else begin
                  state_s = ST_HDR;
               end
            end
            ST_HDR: begin
               if (beat_cnt_r == 16'd7) begin
                  if (ingress_port_tlast) begin
                     state_s = ST_IDLE;
                     if (len_r == 16'd0) begin
                        done_ev_s = 1'b1;
                     end else begin
                        lerr_ev_s = 1'b1;
                     end
                  end else if (len_r == 16'd0) begin
                     lerr_ev_s = 1'b1;
                     state_s   = ST_DRAIN;
                  end else begin
                     state_s = ST_PAY;
                  end
               end else if (ingress_port_tlast) begin
                  runt_ev_s = 1'b1;
                  state_s   = ST_IDLE;
               end else begin
                  state_s = ST_HDR;
               end
            end
            ST_PAY: begin
               csum_s = csum_r + pay_add_s;
               if (last_pay_s) begin
                  if (ingress_port_tlast) begin
                     done_ev_s = 1'b1;
                     state_s   = ST_IDLE;
                  end else begin
                     lerr_ev_s = 1'b1;
                     state_s   = ST_DRAIN;
                  end
               end else if (ingress_port_tlast) begin
                  lerr_ev_s = 1'b1;
                  state_s   = ST_IDLE;
               end else begin
                  state_s = ST_PAY;
               end
            end
            ST_DRAIN: begin
               if (ingress_port_tlast) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_DRAIN;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Parser state, tready and header field capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         beat_cnt_r <= 16'd0;
         csum_r     <= 32'd0;
         tready_r   <= 1'b0;
         len_r      <= 16'd0;
         type_r     <= 16'd0;
         for (int i = 0; i < 3; i++) begin
            dst_w_r[i] <= 16'd0;
            src_w_r[i] <= 16'd0;
         end
      end else begin
         state_r    <= state_s;
         beat_cnt_r <= beat_cnt_s;
         csum_r     <= csum_s;
         tready_r   <= enable_r;
         if (accept_s && (state_r == ST_IDLE)) begin
            dst_w_r[0] <= ingress_port_tdata;
         end else if (accept_s && (state_r == ST_HDR)) begin
            case (beat_cnt_r)
               16'd1:   dst_w_r[1] <= ingress_port_tdata;
               16'd2:   dst_w_r[2] <= ingress_port_tdata;
               16'd3:   src_w_r[0] <= ingress_port_tdata;
               16'd4:   src_w_r[1] <= ingress_port_tdata;
               16'd5:   src_w_r[2] <= ingress_port_tdata;
               16'd6:   len_r      <= {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
               16'd7:   type_r     <= ingress_port_tdata;
               default: ;
            endcase
         end
      end
   end

   // Configuration registers, saturating counters and last-frame snapshots.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 6; i++) begin
            exp_mac_r[i] <= 8'd0;
         end
         for (int i = 0; i < 3; i++) begin
            snap_src_r[i] <= 16'd0;
         end
         enable_r    <= 1'b0;
         promisc_r   <= 1'b0;
         clr_r       <= 1'b0;
         good_cnt_r  <= {CNT_W{1'b0}};
         dmis_cnt_r  <= {CNT_W{1'b0}};
         lerr_cnt_r  <= {CNT_W{1'b0}};
         runt_cnt_r  <= {CNT_W{1'b0}};
         snap_csum_r <= 32'd0;
         snap_len_r  <= 16'd0;
         snap_type_r <= 16'd0;
         last_good_r <= 1'b0;
      end else begin
         clr_r <= clr_wr_s;
         if (wr_s) begin
            case (address)
               8'd0: exp_mac_r[0] <= writedata;
               8'd1: exp_mac_r[1] <= writedata;
               8'd2: exp_mac_r[2] <= writedata;
               8'd3: exp_mac_r[3] <= writedata;
               8'd4: exp_mac_r[4] <= writedata;
               8'd5: exp_mac_r[5] <= writedata;
               8'd6: begin
                  enable_r  <= writedata[0];
                  promisc_r <= writedata[1];
               end
               default: ;
            endcase
         end
         if (clear_s) begin
            good_cnt_r  <= {CNT_W{1'b0}};
            dmis_cnt_r  <= {CNT_W{1'b0}};
            lerr_cnt_r  <= {CNT_W{1'b0}};
            runt_cnt_r  <= {CNT_W{1'b0}};
            snap_csum_r <= 32'd0;
            snap_len_r  <= 16'd0;
            snap_type_r <= 16'd0;
            last_good_r <= 1'b0;
            for (int i = 0; i < 3; i++) begin
               snap_src_r[i] <= 16'd0;
            end
         end else begin
            if (runt_ev_s) begin
               runt_cnt_r  <= sat_inc(runt_cnt_r);
               last_good_r <= 1'b0;
            end
            if (lerr_ev_s) begin
               lerr_cnt_r  <= sat_inc(lerr_cnt_r);
               last_good_r <= 1'b0;
            end
            if (done_ev_s) begin
               if (dst_mis_s) begin
                  dmis_cnt_r  <= sat_inc(dmis_cnt_r);
                  last_good_r <= 1'b0;
               end else begin
                  good_cnt_r  <= sat_inc(good_cnt_r);
                  last_good_r <= 1'b1;
               end
            end
            if (lerr_ev_s || done_ev_s) begin
               snap_csum_r <= csum_s;
               snap_len_r  <= len_r;
               snap_type_r <= frame_type_s;
               for (int i = 0; i < 3; i++) begin
                  snap_src_r[i] <= src_w_r[i];
               end
            end
         end
      end
   end

   // Register read multiplexer.
   always_comb begin
      rd_mux_s = 8'd0;
      case (address)
         8'd0:    rd_mux_s = exp_mac_r[0];
         8'd1:    rd_mux_s = exp_mac_r[1];
         8'd2:    rd_mux_s = exp_mac_r[2];
         8'd3:    rd_mux_s = exp_mac_r[3];
         8'd4:    rd_mux_s = exp_mac_r[4];
         8'd5:    rd_mux_s = exp_mac_r[5];
         8'd6:    rd_mux_s = {6'd0, promisc_r, enable_r};
         8'd8:    rd_mux_s = good16_s[7:0];
         8'd9:    rd_mux_s = good16_s[15:8];
         8'd10:   rd_mux_s = dmis16_s[7:0];
         8'd11:   rd_mux_s = dmis16_s[15:8];
         8'd12:   rd_mux_s = lerr16_s[7:0];
         8'd13:   rd_mux_s = lerr16_s[15:8];
         8'd14:   rd_mux_s = runt16_s[7:0];
         8'd15:   rd_mux_s = runt16_s[15:8];
         8'd16:   rd_mux_s = snap_csum_r[7:0];
         8'd17:   rd_mux_s = snap_csum_r[15:8];
         8'd18:   rd_mux_s = snap_csum_r[23:16];
         8'd19:   rd_mux_s = snap_csum_r[31:24];
         8'd20:   rd_mux_s = snap_len_r[7:0];
         8'd21:   rd_mux_s = snap_len_r[15:8];
         8'd22:   rd_mux_s = snap_type_r[15:8];
         8'd23:   rd_mux_s = snap_type_r[7:0];
         8'd24:   rd_mux_s = snap_src_r[0][15:8];
         8'd25:   rd_mux_s = snap_src_r[0][7:0];
         8'd26:   rd_mux_s = snap_src_r[1][15:8];
         8'd27:   rd_mux_s = snap_src_r[1][7:0];
         8'd28:   rd_mux_s = snap_src_r[2][15:8];
         8'd29:   rd_mux_s = snap_src_r[2][7:0];
         8'd30:   rd_mux_s = {6'd0, last_good_r, (state_r != ST_IDLE)};
         default: rd_mux_s = 8'd0;
      endcase
   end

   // Registered read data, zero outside the cycle after a read.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_r <= 8'd0;
      end else if (chipselect && read) begin
         readdata_r <= rd_mux_s;
      end else begin
         readdata_r <= 8'd0;
      end
   end

endmodule
